// File: rtl/sgd_x_dma_wr_adapter.sv
// Buffers the write-back model data stream and turns each send-back command into
// host DMA write bursts that never exceed MAX_BURST_BYTES or cross a 4 KB page.
module sgd_x_dma_wr_adapter #(
  parameter int DATA_W          = 512,
  parameter int FIFO_DEPTH      = 64,
  parameter int AF_MARGIN       = 8,
  parameter int MAX_BURST_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x_data_send_back_start,
  input  logic [63:0]       x_data_send_back_addr,
  input  logic [31:0]       x_data_send_back_length,
  input  logic [DATA_W-1:0] x_data_out,
  input  logic              x_data_out_valid,
  output logic              x_data_out_almost_full,
  output logic              dma_wr_cmd_valid,
  input  logic              dma_wr_cmd_ready,
  output logic [63:0]       dma_wr_cmd_addr,
  output logic [31:0]       dma_wr_cmd_length,
  output logic [DATA_W-1:0] dma_wr_data,
  output logic              dma_wr_data_valid,
  input  logic              dma_wr_data_ready,
  output logic              dma_wr_data_last,
  output logic              send_back_busy,
  output logic              send_back_done,
  output logic              overflow_err,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [31:0]      MAX_BURST = 32'(MAX_BURST_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_e;

  // Handshakes: a transfer happens on a rising edge where valid && ready; while
  // valid is high with ready low, the payload is held stable.

  state_e              state_q, state_d;
  logic [63:0]         addr_q, addr_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [12:0]         burst_q, burst_d;
  logic [6:0]          beats_q, beats_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                af_q, af_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];

  logic                fifo_full, fifo_empty, push, pop;
  logic [12:0]         page_rem;
  logic [31:0]         burst;

  assign fifo_full  = (count_q == FULL_LVL);
  assign fifo_empty = (count_q == '0);
  // Fullness is judged before this cycle's pop, so a push into a full FIFO drops.
  assign push       = x_data_out_valid && !fifo_full;
  assign pop        = dma_wr_data_valid && dma_wr_data_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= x_data_out;
  end

  always_comb begin
    page_rem = 13'd4096 - {1'b0, addr_q[11:0]};
    burst    = remaining_q;
    if (burst > MAX_BURST)           burst = MAX_BURST;
    if (burst > {19'd0, page_rem})   burst = {19'd0, page_rem};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    af_d  = (count_d >= AF_LVL);
    ovf_d = ovf_q | (x_data_out_valid & fifo_full);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    beats_d     = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (x_data_send_back_start) begin
          addr_d      = x_data_send_back_addr & ~64'h3F;
          remaining_d = x_data_send_back_length & ~32'h3F;
          state_d     = ((x_data_send_back_length & ~32'h3F) == 32'd0) ? ST_DONE : ST_CMD;
        end
      end
      ST_CMD: begin
        if (dma_wr_cmd_ready) begin
          burst_d = burst[12:0];
          beats_d = burst[12:6];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pop) begin
          beats_d = beats_q - 7'd1;
          if (beats_q == 7'd1) begin
            addr_d      = addr_q + {51'd0, burst_q};
            remaining_d = remaining_q - {19'd0, burst_q};
            state_d     = (remaining_q == {19'd0, burst_q}) ? ST_DONE : ST_CMD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      beats_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      af_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      beats_q     <= beats_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      af_q        <= af_d;
      ovf_q       <= ovf_d;
    end
  end

  assign dma_wr_cmd_valid       = (state_q == ST_CMD);
  assign dma_wr_cmd_addr        = dma_wr_cmd_valid ? addr_q : 64'd0;
  assign dma_wr_cmd_length      = dma_wr_cmd_valid ? burst : 32'd0;
  assign dma_wr_data_valid      = (state_q == ST_DATA) && !fifo_empty;
  assign dma_wr_data            = fifo_empty ? '0 : mem[rd_ptr_q];
  assign dma_wr_data_last       = dma_wr_data_valid && (beats_q == 7'd1);
  assign send_back_busy         = (state_q != ST_IDLE);
  assign send_back_done         = (state_q == ST_DONE);
  assign x_data_out_almost_full = af_q;
  assign overflow_err           = ovf_q;
  assign dbg_state              = state_q;

endmodule
